// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// Decode/branch/memory status flows in; stage enables, flush/stall and halt flow out.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [2:0] rs_addr;
  logic [2:0] rt_addr;
  logic       rs_used;
  logic       rt_used;
  logic       id_wr_en;
  logic [2:0] id_wr_addr;
  logic       id_dump;
  logic       br_taken;
  logic       mem_busy;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       stallCtrl;
  logic       pipe_en;
  logic       halted;
  // Current controller state: 0 = RUN, 1 = DRAIN, 2 = HALTED.
  logic [1:0] dbg_state;

  modport master (
    output id_valid, rs_addr, rt_addr, rs_used, rt_used,
           id_wr_en, id_wr_addr, id_dump, br_taken, mem_busy,
    input  pc_en, ifid_en, ifid_flush, stallCtrl, pipe_en, halted, dbg_state
  );

  modport slave (
    input  id_valid, rs_addr, rt_addr, rs_used, rt_used,
           id_wr_en, id_wr_addr, id_dump, br_taken, mem_busy,
    output pc_en, ifid_en, ifid_flush, stallCtrl, pipe_en, halted, dbg_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Interlock controller for a 5-stage pipeline with no forwarding: stalls on RAW
// against EX/MEM writers, flushes on taken branches, freezes on memory busy, drains on Dump.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       ex_v_q, ex_v_d;
  logic [2:0] ex_a_q, ex_a_d;
  logic       mem_v_q, mem_v_d;
  logic [2:0] mem_a_q, mem_a_d;

  logic rs_match, rt_match, hazard, issue;
  logic pc_en, ifid_en, ifid_flush, stall_ctrl, pipe_en, halted;

  // WB is not checked: the register file writes before it is read.
  always_comb begin
    rs_match = (ex_v_q  && (ex_a_q  == hz.rs_addr)) ||
               (mem_v_q && (mem_a_q == hz.rs_addr));
    rt_match = (ex_v_q  && (ex_a_q  == hz.rt_addr)) ||
               (mem_v_q && (mem_a_q == hz.rt_addr));
    hazard   = (hz.rs_used && rs_match) || (hz.rt_used && rt_match);
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    stall_ctrl  = 1'b0;
    pipe_en     = 1'b1;
    halted      = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    ex_v_d      = ex_v_q;
    ex_a_d      = ex_a_q;
    mem_v_d     = mem_v_q;
    mem_a_d     = mem_a_q;

    if (state_q == HALTED) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      stall_ctrl = 1'b1;
      halted     = 1'b1;
    end else if (hz.mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (hz.br_taken) begin
      ifid_flush = 1'b1;
      stall_ctrl = 1'b1;
    end else if ((state_q == DRAIN) || (hz.id_valid && hazard)) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      stall_ctrl = 1'b1;
    end

    issue = hz.id_valid && pipe_en && !hz.br_taken && !hazard && (state_q == RUN);

    if (pipe_en) begin
      // A taken branch kills the instruction leaving EX, so its tag never reaches MEM.
      mem_v_d = ex_v_q && !hz.br_taken;
      mem_a_d = ex_a_q;
      ex_v_d  = issue && hz.id_wr_en;
      ex_a_d  = hz.id_wr_addr;

      case (state_q)
        RUN: begin
          if (issue && hz.id_dump) begin
            state_d     = DRAIN;
            drain_cnt_d = 2'd2;
          end
        end
        DRAIN: begin
          // A branch resolving right behind the Dump means the Dump was on the wrong path.
          if (hz.br_taken && (drain_cnt_q == 2'd2)) begin
            state_d     = RUN;
            drain_cnt_d = 2'd0;
          end else if (drain_cnt_q == 2'd0) begin
            state_d = HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 2'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 2'd0;
      ex_v_q      <= 1'b0;
      ex_a_q      <= 3'd0;
      mem_v_q     <= 1'b0;
      mem_a_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      ex_v_q      <= ex_v_d;
      ex_a_q      <= ex_a_d;
      mem_v_q     <= mem_v_d;
      mem_a_q     <= mem_a_d;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.stallCtrl  = stall_ctrl;
  assign hz.pipe_en    = pipe_en;
  assign hz.halted     = halted;
  assign hz.dbg_state  = state_q;

endmodule
